// File: rtl/filter_sequencer.sv
// Streaming front-end for filter_core: captures the 64-byte header window of each
// packet, asks filter_core for a verdict, then either replays the header and
// forwards the rest of the packet or discards the whole packet.
module filter_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [0:511]        hdr_data,
  input  logic                filters_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_accepted,
  output logic [CNT_W-1:0]    pkt_dropped
);

  localparam int KEEP_W    = DATA_W / 8;
  localparam int HDR_BEATS = 512 / DATA_W;
  localparam int HDR_BYTES = 64;
  localparam int IDX_W     = $clog2(HDR_BEATS);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(HDR_BEATS - 1);

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_DECIDE,
    S_REPLAY,
    S_PASS,
    S_DROP
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     beat_cnt;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_W-1:0]    slot_data [HDR_BEATS];
  logic [KEEP_W-1:0]    slot_keep [HDR_BEATS];
  logic [HDR_BEATS-1:0] slot_last;

  logic s_hs;
  logic m_hs;
  logic pkt_end;

  assign s_hs = s_tvalid && s_tready;
  assign m_hs = m_tvalid && m_tready;
  assign busy = (state != S_CAPTURE);

  // Packet is finished this cycle: the FSM returns to CAPTURE and the slots are wiped.
  assign pkt_end = ((state == S_DECIDE) && !filters_valid && (|slot_last)) ||
                   ((state == S_REPLAY) && m_hs && slot_last[rd_idx])       ||
                   ((state == S_PASS || state == S_DROP) && s_hs && s_tlast);

  // Stream handshake and egress mux: slot replay in REPLAY, straight wire in PASS.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = slot_data[rd_idx];
    m_tkeep  = slot_keep[rd_idx];
    m_tlast  = slot_last[rd_idx];
    case (state)
      S_CAPTURE: s_tready = 1'b1;
      S_DROP:    s_tready = 1'b1;
      S_REPLAY:  m_tvalid = 1'b1;
      S_PASS: begin
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast;
        m_tvalid = s_tvalid;
        s_tready = m_tready;
      end
      default: ;
    endcase
  end

  // Header window: byte k = beat k/8, lane k%8, placed with byte 0 at the top.
  always_comb begin
    hdr_data = '0;
    for (int k = 0; k < HDR_BYTES; k++) begin
      hdr_data[504-8*k +: 8] = slot_data[k/KEEP_W][8*(k%KEEP_W) +: 8];
    end
  end

  // Header slot storage: written during CAPTURE, zeroed whenever a packet ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are reset (not left as plain RAM) because hdr_data must read 0 out of reset.
      for (int i = 0; i < HDR_BEATS; i++) begin
        slot_data[i] <= '0;
        slot_keep[i] <= '0;
      end
      slot_last <= '0;
    end else if (pkt_end) begin
      for (int i = 0; i < HDR_BEATS; i++) begin
        slot_data[i] <= '0;
        slot_keep[i] <= '0;
      end
      slot_last <= '0;
    end else if (state == S_CAPTURE && s_hs) begin
      slot_data[beat_cnt] <= s_tdata;
      slot_keep[beat_cnt] <= s_tkeep;
      slot_last[beat_cnt] <= s_tlast;
    end
  end

  // Packet FSM with beat/replay indices and accept/drop statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state        <= S_CAPTURE;
      beat_cnt     <= '0;
      rd_idx       <= '0;
      pkt_accepted <= '0;
      pkt_dropped  <= '0;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (s_hs) begin
            beat_cnt <= beat_cnt + IDX_W'(1);
            if (beat_cnt == LAST_SLOT || s_tlast) state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          beat_cnt <= '0;
          rd_idx   <= '0;
          if (filters_valid) begin
            pkt_accepted <= pkt_accepted + CNT_W'(1);
            state        <= S_REPLAY;
          end else begin
            pkt_dropped <= pkt_dropped + CNT_W'(1);
            state       <= (|slot_last) ? S_CAPTURE : S_DROP;
          end
        end
        S_REPLAY: begin
          if (m_hs) begin
            rd_idx <= rd_idx + IDX_W'(1);
            if (slot_last[rd_idx])       state <= S_CAPTURE;
            else if (rd_idx == LAST_SLOT) state <= S_PASS;
          end
        end
        S_PASS, S_DROP: begin
          if (s_hs && s_tlast) state <= S_CAPTURE;
        end
        default: state <= S_CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_sequencer.sv
// Randomized bench for filter_sequencer: packet-level reference model with an
// egress scoreboard, a small filter_core stand-in, and AXIS stability checks.
module tb_filter_sequencer;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int CNT_W  = 32;
  localparam logic [47:0] DMAC = 48'h02_11_22_33_44_55;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic [KEEP_W-1:0] s_tkeep = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [0:511]      hdr_data;
  logic              filters_valid;
  logic              busy;
  logic [CNT_W-1:0]  pkt_accepted;
  logic [CNT_W-1:0]  pkt_dropped;

  filter_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .hdr_data(hdr_data), .filters_valid(filters_valid), .busy(busy),
    .pkt_accepted(pkt_accepted), .pkt_dropped(pkt_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // filter_core stand-in: dest MAC match plus IPv4 protocol == UDP
  function automatic logic [7:0] hdr_byte(input logic [0:511] h, input int k);
    return h[504-8*k +: 8];
  endfunction

  function automatic logic match_hdr(input logic [0:511] h);
    for (int i = 0; i < 6; i++)
      if (hdr_byte(h, i) != DMAC[47-8*i -: 8]) return 1'b0;
    return hdr_byte(h, 23) == 8'd17;
  endfunction

  always_comb filters_valid = match_hdr(hdr_data);

  // ---------------- reference model ----------------
  logic [7:0] pkt[$];
  beat_t      exp_q[$];
  int         exp_acc = 0;
  int         exp_drop = 0;
  bit         rand_rdy = 0;
  bit         abort = 0;

  task automatic build_pkt(input int len, input bit hit);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    if (len >= 6) for (int i = 0; i < 6; i++) pkt[i] = DMAC[47-8*i -: 8];
    if (len >= 24) pkt[23] = 8'd17;
    if (!hit && len > 0) pkt[0] = pkt[0] ^ 8'h80;
  endtask

  function automatic bit model_accept();
    if (pkt.size() < 24) return 1'b0;
    for (int i = 0; i < 6; i++)
      if (pkt[i] != DMAC[47-8*i -: 8]) return 1'b0;
    return pkt[23] == 8'd17;
  endfunction

  function automatic beat_t mk_beat(input int b);
    beat_t r;
    r = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      if (8*b + j < pkt.size()) begin
        r.data[8*j +: 8] = pkt[8*b+j];
        r.keep[j]        = 1'b1;
      end
    end
    r.last = (8*b + 8 >= pkt.size());
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
  end

  // Ingress driver; called at posedge+1, returns at posedge+1.
  task automatic send_pkt(input bit gaps, output int hdr_cyc, output int low_cnt);
    int    nb;
    int    hdr_b;
    int    guard;
    bit    hs;
    beat_t bt;
    nb      = (pkt.size() + 7) / 8;
    hdr_b   = (nb < 8) ? nb - 1 : 7;
    low_cnt = 0;
    hdr_cyc = -1;
    if (model_accept()) begin
      exp_acc++;
      for (int b = 0; b < nb; b++) exp_q.push_back(mk_beat(b));
    end else begin
      exp_drop++;
    end
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      bt       = mk_beat(b);
      s_tdata  = bt.data;
      s_tkeep  = bt.keep;
      s_tlast  = bt.last;
      s_tvalid = 1'b1;
      hs       = 1'b0;
      guard    = 0;
      while (!hs) begin
        @(negedge clk);
        if (!s_tready) low_cnt++;
        hs = s_tready;
        if (hs && b == hdr_b) hdr_cyc = cyc;
        @(posedge clk); #1;
        if (abort) begin
          s_tvalid = 1'b0;
          return;
        end
        guard++;
        if (!hs && guard > 2000) begin
          check("ingress_timeout_ready", s_tready, 1);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // ---------------- egress monitor ----------------
  int    egress_cnt = 0;
  int    vld_rise_cyc = -1;
  bit    prev_stall = 0;
  bit    prev_vld = 0;
  beat_t prev_beat;
  beat_t got_beat;
  beat_t exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      prev_vld   = 0;
    end else begin
      got_beat = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
      if (prev_stall) begin
        check("axis_valid_held", m_tvalid, 1);
        check("axis_beat_held", got_beat, prev_beat);
      end
      if (m_tvalid && !prev_vld) vld_rise_cyc = cyc;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_egress_valid", m_tvalid, 0);
        end else begin
          exp_beat = exp_q.pop_front();
          check("egress_beat", got_beat, exp_beat);
          egress_cnt++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_vld   = m_tvalid;
      prev_beat  = got_beat;
    end
  end

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_busy", busy, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 1);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_accepted"}, pkt_accepted, 0);
    check({tag, "_dropped"}, pkt_dropped, 0);
    check({tag, "_hdr_zero"}, |hdr_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int hdr_cyc;
  int low_cnt;
  int eg0;
  int bg_hdr;
  int bg_low;
  logic [7:0] tail_or;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: matching 12-beat packet, full-rate egress
    build_pkt(96, 1);
    eg0 = egress_cnt;
    send_pkt(0, hdr_cyc, low_cnt);
    wait_drain();
    check("t1_latency", vld_rise_cyc - hdr_cyc, 2);
    check("t1_beats", egress_cnt - eg0, 12);
    check("t1_accepted", pkt_accepted, exp_acc);

    // 2: dest MAC mismatch, 12 beats absorbed
    build_pkt(96, 0);
    eg0 = egress_cnt;
    send_pkt(0, hdr_cyc, low_cnt);
    wait_drain();
    check("t2_ready_low_cycles", low_cnt, 1);
    check("t2_beats", egress_cnt - eg0, 0);
    check("t2_dropped", pkt_dropped, exp_drop);

    // 3: short 5-beat packet with partial last beat
    build_pkt(36, 1);
    eg0 = egress_cnt;
    send_pkt(0, hdr_cyc, low_cnt);
    check("t3_decide_ready", s_tready, 0);
    check("t3_decide_busy", busy, 1);
    tail_or = '0;
    for (int k = 40; k < 64; k++) tail_or = tail_or | hdr_byte(hdr_data, k);
    check("t3_hdr_tail_zero", tail_or, 0);
    for (int k = 32; k < 36; k++) check("t3_hdr_byte", hdr_byte(hdr_data, k), pkt[k]);
    wait_drain();
    check("t3_beats", egress_cnt - eg0, 5);
    check("t3_accepted", pkt_accepted, exp_acc);

    // 4: 20 random packets, ingress gaps, random egress backpressure
    rand_rdy = 1;
    for (int p = 0; p < 20; p++) begin
      build_pkt(int'($urandom_range(1, 130)), $urandom_range(3) != 0);
      send_pkt(1, hdr_cyc, low_cnt);
    end
    rand_rdy = 0;
    wait_drain();
    check("t4_accepted", pkt_accepted, exp_acc);
    check("t4_dropped", pkt_dropped, exp_drop);
    check("t4_total", pkt_accepted + pkt_dropped, 23);

    // 5: async reset in the middle of REPLAY
    build_pkt(96, 1);
    eg0 = egress_cnt;
    abort = 0;
    fork
      send_pkt(0, bg_hdr, bg_low);
    join_none
    for (int g = 0; g < 500 && egress_cnt < eg0 + 3; g++) @(negedge clk);
    check("t5_in_replay", m_tvalid, 1);
    abort = 1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    exp_q.delete();
    exp_acc  = 0;
    exp_drop = 0;
    @(negedge clk);
    abort = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_pkt(80, 1);
    eg0 = egress_cnt;
    send_pkt(1, hdr_cyc, low_cnt);
    wait_drain();
    check("t5_beats", egress_cnt - eg0, 10);
    check("t5_accepted", pkt_accepted, 1);

    // 6: dropped counter wraps from all-ones
    @(negedge clk);
    force dut.pkt_dropped = '1;
    @(posedge clk); #1;
    release dut.pkt_dropped;
    build_pkt(20, 0);
    send_pkt(0, hdr_cyc, low_cnt);
    wait_drain();
    check("t6_dropped_wrap", pkt_dropped, 0);
    check("t6_accepted", pkt_accepted, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
